// File: rtl/crc_engine.sv
// crc_engine: parametrised CRC generator/checker with a framed valid/ready
// beat interface and a held result handshake carrying the CRC and beat count.
module crc_engine #(
    parameter int               CRC_W       = 16,
    parameter logic [CRC_W-1:0] POLY        = 16'h8005,
    parameter logic [CRC_W-1:0] INIT        = 16'h0000,
    parameter logic [CRC_W-1:0] XOR_OUT     = 16'h0000,
    parameter int               DATA_W      = 8,
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0,
    parameter int               LEN_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    output logic [CRC_W-1:0]  crc_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              crc_valid_o,
    input  logic              crc_ready_i,
    output logic              err_o
);

    // FIN is the single cycle where the register is folded into the result
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   out_q, out_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               err_q, err_d;
    logic               beat;

    // DATA_W serial LFSR steps unrolled into one combinational update
    function automatic logic [CRC_W-1:0] lfsr_upd(input logic [CRC_W-1:0] r,
                                                   input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             b;
        logic             fb;
        c = r;
        for (int i = 0; i < DATA_W; i++) begin
            b  = REFLECT_IN ? d[i] : d[DATA_W-1-i];
            fb = c[CRC_W-1] ^ b;
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] r);
        logic [CRC_W-1:0] v;
        for (int i = 0; i < CRC_W; i++)
            v[i] = REFLECT_OUT ? r[CRC_W-1-i] : r[i];
        return v ^ XOR_OUT;
    endfunction

    assign ready_o     = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign crc_valid_o = (state_q == S_DONE);
    assign crc_o       = out_q;
    assign len_o       = len_q;
    assign err_o       = err_q;
    assign beat        = valid_i && ready_o;

    // next-state, register update, beat counting and error detection
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        len_d   = len_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    if (sop_i) begin
                        crc_d   = lfsr_upd(INIT, data_i);
                        cnt_d   = LEN_W'(1);
                        state_d = eop_i ? S_FIN : S_ACCUM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    if (sop_i) begin
                        // a stray sop restarts the frame with this beat
                        err_d = 1'b1;
                        crc_d = lfsr_upd(INIT, data_i);
                        cnt_d = LEN_W'(1);
                    end else begin
                        crc_d = lfsr_upd(crc_q, data_i);
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
                    end
                    if (eop_i) state_d = S_FIN;
                end
            end
            S_FIN: begin
                out_d   = finalize(crc_q);
                len_d   = cnt_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (crc_ready_i) begin
                    state_d = S_IDLE;
                    crc_d   = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
            out_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: byte-wide default, CRC-16/ARC and CRC-32
// instances share one stimulus stream; a DATA_W=1 instance covers legacy mode.
module tb_crc_engine;

    typedef struct {
        logic [31:0] crc;
        logic [15:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, sop, eop, crc_rdy;
    logic [7:0]  data;
    logic        v1, d1, s1, e1, cr1;

    logic        rdy8, v8, er8;
    logic [15:0] c8, l8;
    logic        rdya, va, era;
    logic [15:0] ca, la;
    logic        rdy32, v32, er32;
    logic [31:0] c32;
    logic [15:0] l32;
    logic        rdy1, cv1, er1;
    logic [15:0] c1, l1;

    int   errors = 0;
    int   checks = 0;
    exp_t q8[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    crc_engine u8 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(rdy8), .data_i(data),
        .sop_i(sop), .eop_i(eop), .crc_o(c8), .len_o(l8), .crc_valid_o(v8),
        .crc_ready_i(crc_rdy), .err_o(er8));

    crc_engine #(.REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u_arc (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(rdya), .data_i(data),
        .sop_i(sop), .eop_i(eop), .crc_o(ca), .len_o(la), .crc_valid_o(va),
        .crc_ready_i(crc_rdy), .err_o(era));

    crc_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                 .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u32 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(rdy32), .data_i(data),
        .sop_i(sop), .eop_i(eop), .crc_o(c32), .len_o(l32), .crc_valid_o(v32),
        .crc_ready_i(crc_rdy), .err_o(er32));

    crc_engine #(.DATA_W(1)) u1 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(v1), .ready_o(rdy1), .data_i(d1),
        .sop_i(s1), .eop_i(e1), .crc_o(c1), .len_o(l1), .crc_valid_o(cv1),
        .crc_ready_i(cr1), .err_o(er1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // plain CRC-16/8005, init 0, MSB first: reference for the default instance
    function automatic logic [15:0] crc16_ref(input logic [7:0] b[$]);
        logic [15:0] r;
        logic        fb;
        r = 16'h0000;
        foreach (b[k])
            for (int j = 7; j >= 0; j--) begin
                fb = r[15] ^ b[k][j];
                r  = fb ? ((r << 1) ^ 16'h8005) : (r << 1);
            end
        return r;
    endfunction

    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        valid = 1'b1; data = d; sop = s; eop = e;
        tick();
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b[$]);
        exp_t x;
        x.crc = {16'h0, crc16_ref(b)};
        x.len = 16'(b.size());
        q8.push_back(x);
        foreach (b[k]) beat(b[k], k == 0, k == b.size() - 1);
    endtask

    task automatic get_result8(input string tag);
        exp_t x;
        int   n;
        n = 0;
        while (!v8 && n < 20) begin tick(); n++; end
        check({tag, "_valid"}, v8, 1'b1);
        if (q8.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
        end else begin
            x = q8.pop_front();
            check({tag, "_crc"}, c8, x.crc);
            check({tag, "_len"}, l8, x.len);
        end
        crc_rdy = 1'b1;
        tick();
        check({tag, "_drop"}, v8, 1'b0);
    endtask

    task automatic get_result1(input string tag);
        exp_t x;
        int   n;
        n = 0;
        while (!cv1 && n < 20) begin tick(); n++; end
        check({tag, "_valid"}, cv1, 1'b1);
        if (q1.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
        end else begin
            x = q1.pop_front();
            check({tag, "_crc"}, c1, x.crc);
            check({tag, "_len"}, l1, x.len);
        end
        tick();
        check({tag, "_drop"}, cv1, 1'b0);
    endtask

    initial begin
        logic [7:0]  msg[$];
        logic [7:0]  fr[$];
        logic [15:0] hc, hl, r;
        logic        bit_v, fb;
        exp_t        x;
        int          n;

        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst_n = 1'b0; valid = 1'b0; sop = 1'b0; eop = 1'b0; data = '0; crc_rdy = 1'b1;
        v1 = 1'b0; d1 = 1'b0; s1 = 1'b0; e1 = 1'b0; cr1 = 1'b1;
        tick(); tick();
        check("rst_ready", rdy8, 1'b1);
        check("rst_valid", v8, 1'b0);
        check("rst_crc", c8, 16'h0);
        check("rst_len", l8, 16'h0);
        check("rst_err", er8, 1'b0);
        rst_n = 1'b1;
        tick();

        // check string on all three byte-wide flavours, plus result latency
        send_frame(msg);
        check("lat_eop_edge", v8, 1'b0);
        tick();
        check("lat_next_edge", v8, 1'b1);
        check("std_fee8", c8, 16'hFEE8);
        check("arc_bb3d", ca, 16'hBB3D);
        check("crc32", c32, 32'hCBF43926);
        check("std_len9", l8, 16'd9);
        get_result8("std");
        check("std_idle_ready", rdy8, 1'b1);

        // backpressure: result held, offered beats ignored
        crc_rdy = 1'b0;
        fr = {};
        for (int k = 0; k < 4; k++) fr.push_back(8'($urandom));
        send_frame(fr);
        n = 0;
        while (!v8 && n < 20) begin tick(); n++; end
        hc = c8; hl = l8;
        valid = 1'b1; sop = 1'b1; eop = 1'b1; data = 8'h55;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_ready", rdy8, 1'b0);
            check("bp_crc_hold", c8, hc);
            check("bp_len_hold", l8, hl);
        end
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
        get_result8("bp");
        check("bp_ready_after", rdy8, 1'b1);
        fr = {};
        for (int k = 0; k < 5; k++) fr.push_back(8'($urandom));
        send_frame(fr);
        get_result8("bp_next");

        // beat without sop in IDLE
        beat(8'hAA, 1'b0, 1'b0);
        check("idle_err", er8, 1'b1);
        check("idle_no_valid", v8, 1'b0);
        tick();
        check("idle_err_pulse", er8, 1'b0);
        send_frame(msg);
        get_result8("after_err");

        // sop mid-frame restarts with the new frame only
        beat(8'h61, 1'b1, 1'b0);
        beat(8'h62, 1'b0, 1'b0);
        beat(8'h63, 1'b0, 1'b0);
        fr = '{8'h78, 8'h79, 8'h7A};
        x.crc = {16'h0, crc16_ref(fr)};
        x.len = 16'd3;
        q8.push_back(x);
        beat(8'h78, 1'b1, 1'b0);
        check("mid_sop_err", er8, 1'b1);
        beat(8'h79, 1'b0, 1'b0);
        check("mid_sop_err_pulse", er8, 1'b0);
        beat(8'h7A, 1'b0, 1'b1);
        get_result8("mid_sop");

        // reset mid-frame
        for (int k = 0; k < 4; k++) beat(msg[k], k == 0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_ready", rdy8, 1'b1);
        check("mid_rst_valid", v8, 1'b0);
        check("mid_rst_len", l8, 16'h0);
        send_frame(msg);
        get_result8("after_rst");

        // legacy serial mode: 50 random bits
        r = 16'h0000;
        for (int k = 0; k < 50; k++) begin
            bit_v = 1'($urandom);
            fb = r[15] ^ bit_v;
            r  = fb ? ((r << 1) ^ 16'h8005) : (r << 1);
            v1 = 1'b1; d1 = bit_v; s1 = (k == 0); e1 = (k == 49);
            tick();
        end
        x.crc = {16'h0, r};
        x.len = 16'd50;
        q1.push_back(x);
        v1 = 1'b0; s1 = 1'b0; e1 = 1'b0;
        get_result1("legacy50");

        x.crc = 32'h8005;
        x.len = 16'd1;
        q1.push_back(x);
        v1 = 1'b1; d1 = 1'b1; s1 = 1'b1; e1 = 1'b1;
        tick();
        v1 = 1'b0; s1 = 1'b0; e1 = 1'b0;
        get_result1("legacy1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
